// File: rtl/instr_mem_pkg.sv
// Shared types and constants for the program-loadable instruction memory.
package instr_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [31:0] NOP_WORD          = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

  function automatic int cnt_width(input int bpw);
    return (bpw > 1) ? $clog2(bpw) : 1;
  endfunction

endpackage

// File: rtl/instr_mem_loader_if.sv
// Load-stream and fetch signals of the instruction memory.
interface instr_mem_loader_if #(
  parameter int MEM_SIZE    = 1024,
  parameter int WORD_WIDTH  = 32,
  parameter int ADDR_LENGTH = 32,
  parameter int BYTE_WIDTH  = 8
);
  logic                      i_load_start;
  logic                      i_byte_valid;
  logic [BYTE_WIDTH-1:0]     i_byte;
  logic                      o_byte_ready;
  logic                      o_load_done;
  logic [$clog2(MEM_SIZE):0] o_word_count;
  logic                      i_fetch_en;
  logic [ADDR_LENGTH-1:0]    i_Addr;
  logic [WORD_WIDTH-1:0]     o_Data;
  logic                      o_Data_valid;
  logic                      o_addr_err;

  modport master (
    output i_load_start, i_byte_valid, i_byte, i_fetch_en, i_Addr,
    input  o_byte_ready, o_load_done, o_word_count, o_Data, o_Data_valid, o_addr_err
  );

  modport slave (
    input  i_load_start, i_byte_valid, i_byte, i_fetch_en, i_Addr,
    output o_byte_ready, o_load_done, o_word_count, o_Data, o_Data_valid, o_addr_err
  );
endinterface

// File: rtl/word_packer.sv
// Packs an MSB-first byte stream into words; word/word_valid are combinational
// so the completed word can be written on the same edge as its last byte.
module word_packer
  import instr_mem_pkg::*;
#(
  parameter int WORD_WIDTH = 32,
  parameter int BYTE_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  byte_en,
  input  logic [BYTE_WIDTH-1:0] byte_in,
  output logic                  word_valid,
  output logic [WORD_WIDTH-1:0] word
);
  localparam int BPW = WORD_WIDTH / BYTE_WIDTH;
  localparam int CW  = cnt_width(BPW);

  logic [CW-1:0]                    cnt;
  logic [WORD_WIDTH-BYTE_WIDTH-1:0] shreg;

  assign word       = {shreg, byte_in};
  assign word_valid = byte_en && (cnt == CW'(BPW - 1));

  always_ff @(posedge clk) begin
    if (reset || clear)
      cnt <= '0;
    else if (byte_en)
      cnt <= word_valid ? '0 : cnt + CW'(1);
  end

  // stale bytes are shifted out by the next full word, so clear leaves shreg alone
  always_ff @(posedge clk) begin
    if (reset)
      shreg <= '0;
    else if (byte_en)
      shreg <= word[WORD_WIDTH-BYTE_WIDTH-1:0];
  end
endmodule

// File: rtl/instr_mem_loader.sv
// Instruction memory loaded byte-wise from the debug unit, then fetched with
// one-cycle registered latency.  States: IDLE reset | LOAD accepting bytes | DONE memory valid.
module instr_mem_loader
  import instr_mem_pkg::*;
#(
  parameter int                    MEM_SIZE    = 1024,
  parameter int                    WORD_WIDTH  = 32,
  parameter int                    ADDR_LENGTH = 32,
  parameter int                    BYTE_WIDTH  = 8,
  parameter logic [WORD_WIDTH-1:0] HALT_WORD   = WORD_WIDTH'(DEFAULT_HALT_WORD)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  instr_mem_loader_if.slave bus
);
  localparam int AW = $clog2(MEM_SIZE);

  state_t                state, state_nxt;
  logic [AW:0]           wr_ptr;
  logic [WORD_WIDTH-1:0] mem [MEM_SIZE];
  logic                  start, byte_en, word_valid, last_word, addr_bad;
  logic [WORD_WIDTH-1:0] word;
  logic [AW-1:0]         rd_idx;

  assign start     = bus.i_load_start && (state != ST_LOAD);
  assign byte_en   = bus.i_byte_valid && bus.o_byte_ready;
  assign last_word = (word == HALT_WORD) || (wr_ptr == (AW+1)'(MEM_SIZE - 1));
  assign addr_bad  = (|bus.i_Addr[1:0]) || (|bus.i_Addr[ADDR_LENGTH-1:AW+2]);
  assign rd_idx    = bus.i_Addr[AW+1:2];

  word_packer #(
    .WORD_WIDTH (WORD_WIDTH),
    .BYTE_WIDTH (BYTE_WIDTH)
  ) u_packer (
    .clk        (i_clk),
    .reset      (i_reset),
    .clear      (start),
    .byte_en    (byte_en),
    .byte_in    (bus.i_byte),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: if (bus.i_load_start) state_nxt = ST_LOAD;
      ST_LOAD:          if (word_valid && last_word) state_nxt = ST_DONE;
      default:          state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.o_byte_ready = (state == ST_LOAD);
    bus.o_load_done  = (state == ST_DONE);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || start) wr_ptr <= '0;
    else if (word_valid)  wr_ptr <= wr_ptr + (AW+1)'(1);
  end

  assign bus.o_word_count = wr_ptr;

  // contents survive reset and reloads; word_valid only fires with wr_ptr < MEM_SIZE
  always_ff @(posedge i_clk) begin
    if (word_valid) mem[wr_ptr[AW-1:0]] <= word;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      bus.o_Data       <= '0;
      bus.o_Data_valid <= 1'b0;
      bus.o_addr_err   <= 1'b0;
    end else begin
      bus.o_Data_valid <= 1'b0;
      if (bus.i_fetch_en && state != ST_LOAD) begin
        bus.o_Data_valid <= 1'b1;
        if (addr_bad) begin
          bus.o_Data     <= WORD_WIDTH'(NOP_WORD);
          bus.o_addr_err <= 1'b1;
        end else begin
          bus.o_Data     <= mem[rd_idx];
          bus.o_addr_err <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader with a queue-based reference model checked every cycle.
module tb_instr_mem_loader;
  localparam int          MEM_SIZE = 1024;
  localparam logic [31:0] HALT     = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  instr_mem_loader_if #(.MEM_SIZE(MEM_SIZE), .WORD_WIDTH(32), .ADDR_LENGTH(32), .BYTE_WIDTH(8)) bus ();

  instr_mem_loader #(
    .MEM_SIZE(MEM_SIZE), .WORD_WIDTH(32), .ADDR_LENGTH(32), .BYTE_WIDTH(8), .HALT_WORD(HALT)
  ) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: bytes queue up until a word is complete
  logic [7:0]  m_q[$];
  logic [31:0] m_mem [MEM_SIZE];
  bit          m_loading, m_done, m_valid, m_err;
  int          m_count;
  logic [31:0] m_data;

  always @(posedge clk) begin
    logic [31:0] w;
    if (reset) begin
      m_loading = 0; m_done = 0; m_q.delete(); m_count = 0;
      m_data = 0; m_valid = 0; m_err = 0;
    end else begin
      m_valid = 0;
      if (!m_loading) begin
        if (bus.i_fetch_en) begin
          m_valid = 1;
          if (bus.i_Addr % 4 != 0 || bus.i_Addr >= MEM_SIZE * 4) begin
            m_data = 0; m_err = 1;
          end else begin
            m_data = m_mem[bus.i_Addr / 4]; m_err = 0;
          end
        end
        if (bus.i_load_start) begin
          m_loading = 1; m_done = 0; m_q.delete(); m_count = 0;
        end
      end else if (bus.i_byte_valid) begin
        m_q.push_back(bus.i_byte);
        if (m_q.size() == 4) begin
          w = {m_q[0], m_q[1], m_q[2], m_q[3]};
          m_q.delete();
          m_mem[m_count] = w;
          m_count++;
          if (w == HALT || m_count == MEM_SIZE) begin
            m_loading = 0; m_done = 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("byte_ready", 32'(bus.o_byte_ready), 32'(m_loading));
      chk("load_done",  32'(bus.o_load_done),  32'(m_done));
      chk("word_count", 32'(bus.o_word_count), 32'(m_count));
      chk("data",       bus.o_Data,            m_data);
      chk("data_valid", 32'(bus.o_Data_valid), 32'(m_valid));
      chk("addr_err",   32'(bus.o_addr_err),   32'(m_err));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load();
    bus.i_load_start = 1'b1;
    tick();
    bus.i_load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.i_byte_valid = 1'b1;
    bus.i_byte       = b;
    tick();
    bus.i_byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      bus.i_byte_valid = 1'b1;
      bus.i_byte       = w[31-8*i -: 8];
      tick();
    end
    bus.i_byte_valid = 1'b0;
  endtask

  task automatic fetch_chk(input string name, input logic [31:0] addr,
                           input logic [31:0] exp_data, input logic exp_err);
    bus.i_fetch_en = 1'b1;
    bus.i_Addr     = addr;
    tick();
    bus.i_fetch_en = 1'b0;
    chk({name, "_valid"}, 32'(bus.o_Data_valid), 32'd1);
    chk({name, "_data"},  bus.o_Data, exp_data);
    chk({name, "_err"},   32'(bus.o_addr_err), 32'(exp_err));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_load_start = 0; bus.i_byte_valid = 0; bus.i_byte = 0;
    bus.i_fetch_en = 0; bus.i_Addr = 0;
    reset = 1'b1;
    tick();
    cmp_en = 1'b1;
    tick(); tick();
    reset = 1'b0;
    chk("rst_ready", 32'(bus.o_byte_ready), 32'd0);
    chk("rst_done",  32'(bus.o_load_done),  32'd0);
    chk("rst_count", 32'(bus.o_word_count), 32'd0);
    chk("rst_data",  bus.o_Data, 32'd0);

    // basic load with halt
    start_load();
    chk("start_ready", 32'(bus.o_byte_ready), 32'd1);
    send_word(32'h1234_5678);
    send_word(HALT);
    chk("halt_done",  32'(bus.o_load_done),  32'd1);
    chk("halt_count", 32'(bus.o_word_count), 32'd2);
    chk("halt_ready", 32'(bus.o_byte_ready), 32'd0);
    fetch_chk("f0", 32'd0, 32'h1234_5678, 1'b0);
    fetch_chk("f4", 32'd4, HALT, 1'b0);
    tick();
    chk("f_idle_valid", 32'(bus.o_Data_valid), 32'd0);
    fetch_chk("f_mis", 32'd2, 32'd0, 1'b1);
    fetch_chk("f_oob", 32'(MEM_SIZE * 4), 32'd0, 1'b1);
    fetch_chk("f0b", 32'd0, 32'h1234_5678, 1'b0);

    // fill the whole memory without a halt word
    start_load();
    for (int i = 0; i < MEM_SIZE; i++) send_word(32'hA000_0000 | 32'(i));
    chk("full_done",  32'(bus.o_load_done),  32'd1);
    chk("full_count", 32'(bus.o_word_count), 32'(MEM_SIZE));
    chk("full_ready", 32'(bus.o_byte_ready), 32'd0);
    send_byte(8'h55);
    send_word(32'h5555_5555);
    chk("full_count2", 32'(bus.o_word_count), 32'(MEM_SIZE));
    fetch_chk("full_f0",   32'd0, 32'hA000_0000, 1'b0);
    fetch_chk("full_last", 32'(MEM_SIZE * 4 - 4), 32'hA000_0000 | 32'(MEM_SIZE - 1), 1'b0);

    // reset in the middle of word 3
    start_load();
    send_word(32'hB000_0000);
    send_word(32'hB000_0001);
    send_word(32'hB000_0002);
    send_byte(8'hEE);
    send_byte(8'hEE);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_count", 32'(bus.o_word_count), 32'd0);
    chk("mid_ready", 32'(bus.o_byte_ready), 32'd0);
    chk("mid_done",  32'(bus.o_load_done),  32'd0);
    fetch_chk("mid_f0",  32'd0,  32'hB000_0000, 1'b0);
    fetch_chk("mid_f8",  32'd8,  32'hB000_0002, 1'b0);
    fetch_chk("mid_f12", 32'd12, 32'hA000_0003, 1'b0);

    // partial word must not leak into the next load
    start_load();
    send_word(32'hD1D2_D3D4);
    send_word(HALT);
    fetch_chk("part_f0", 32'd0, 32'hD1D2_D3D4, 1'b0);

    // fetch and restart requests are ignored while loading
    start_load();
    bus.i_fetch_en = 1'b1;
    bus.i_Addr     = 32'd4;
    tick();
    bus.i_fetch_en = 1'b0;
    chk("ld_fetch_valid", 32'(bus.o_Data_valid), 32'd0);
    chk("ld_fetch_hold",  bus.o_Data, 32'hD1D2_D3D4);
    send_byte(8'hC1);
    send_byte(8'hC2);
    start_load();
    send_byte(8'hC3);
    send_byte(8'hC4);
    chk("restart_count", 32'(bus.o_word_count), 32'd1);
    send_word(HALT);
    fetch_chk("restart_f0", 32'd0, 32'hC1C2_C3C4, 1'b0);
    tick();

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
